fns_enc_4_2_seq: RTL and testbench

- Sequential Fibonacci-numeral-system (FNS) encoder for one 6-wire crosstalk-avoidance group. It sits directly upstream of the 6-wire group decoder.
- Accepts a binary data word and greedily encodes it into a 6-bit codeword, MSB wire first, one wire per clock.
- Wires with en_flag=0 are skipped and driven 0, matching the decoder's masking.
- Uses valid/ready handshakes on both the input side and the codeword side.

---
 rtl/fns_enc_4_2_seq_if.sv | 37 +++
 rtl/fns_enc_4_2_seq.sv | 144 ++++++++++++++
 tb/tb_fns_enc_4_2_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fns_enc_4_2_seq_if.sv
// Handshake bundle between a data source, the FNS encoder and the 6-wire
// group decoder downstream.
//
// Handshake rule for both sides: a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holds valid and its payload
// stable until that edge. A sink may raise or drop ready at any time.
//
// Signals:
//   data_in   binary word to encode         (source -> encoder)
//   in_valid  data_in valid                 (source -> encoder)
//   in_ready  encoder can accept data       (encoder -> source)
//   codeout   6-bit codeword, wire 5 = MSB  (encoder -> sink)
//   enc_err   word not representable        (encoder -> sink)
//   out_valid codeout/enc_err valid         (encoder -> sink)
//   out_ready sink accepts the codeword     (sink -> encoder)
// Modports: slave = encoder side, master = bench/system side.
interface fns_enc_4_2_seq_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        codeout;
  logic              out_valid;
  logic              out_ready;
  logic              enc_err;

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, codeout, out_valid, enc_err
  );

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, codeout, out_valid, enc_err
  );
endinterface

// File: rtl/fns_enc_4_2_seq.sv
// Sequential Fibonacci-numeral-system encoder for one 6-wire
// crosstalk-avoidance group. Greedy encoding, one wire per clock, wire 5
// first. Disabled wires are skipped and driven 0.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   bus        handshake bundle (slave modport): data_in/in_valid/in_ready,
//              codeout/enc_err/out_valid/out_ready
//   en_flag    per-wire enable, [5:0] = wires 5..0
//   FNS03..06  programmable weights of wires 2..5 (wires 0,1 weigh 1)
//   fsm_state  debug view of the FSM state (0=IDLE, 1=ENC, 2=HOLD)
module fns_enc_4_2_seq #(
  parameter int DATA_W = 4,
  parameter int WW     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fns_enc_4_2_seq_if.slave     bus,
  input  logic [5:0]           en_flag,
  input  logic [WW-1:0]        FNS03,
  input  logic [WW-1:0]        FNS04,
  input  logic [WW-1:0]        FNS05,
  input  logic [WW-1:0]        FNS06,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_next;

  // Shadow copies taken at acceptance so the word in flight is immune to
  // later changes of enables or weights.
  logic [5:0]    en_s;
  logic [WW-1:0] w2_s, w3_s, w4_s, w5_s;

  logic [WW-1:0]     rem;
  logic [2:0]        idx;
  logic [5:0]        code_sr;
  logic [5:0]        codeout_r;
  logic              enc_err_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] data_w;

  logic [WW-1:0] w_sel;
  logic          bit_cur;
  logic [WW-1:0] rem_next;
  logic [5:0]    code_next;

  assign data_w        = bus.data_in;
  assign bus.in_ready  = (state == IDLE);
  assign bus.codeout   = codeout_r;
  assign bus.enc_err   = enc_err_r;
  assign bus.out_valid = out_valid_r;
  assign fsm_state     = state;

  // Weight of the wire currently being decided.
  always_comb begin
    w_sel = WW'(1);
    case (idx)
      3'd2:    w_sel = w2_s;
      3'd3:    w_sel = w3_s;
      3'd4:    w_sel = w4_s;
      3'd5:    w_sel = w5_s;
      default: w_sel = WW'(1);
    endcase
  end

  // Greedy step. A zero weight on an enabled wire always sets the bit and
  // leaves the remainder untouched, which falls out of the unsigned compare.
  always_comb begin
    bit_cur        = en_s[idx] && (rem >= w_sel);
    rem_next       = bit_cur ? (rem - w_sel) : rem;
    code_next      = code_sr;
    code_next[idx] = bit_cur;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = ENC;
      ENC:     if (idx == 3'd0)   state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      idx         <= '0;
      code_sr     <= '0;
      en_s        <= '0;
      w2_s        <= '0;
      w3_s        <= '0;
      w4_s        <= '0;
      w5_s        <= '0;
      codeout_r   <= '0;
      enc_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rem     <= WW'(data_w);
            en_s    <= en_flag;
            w2_s    <= FNS03;
            w3_s    <= FNS04;
            w4_s    <= FNS05;
            w5_s    <= FNS06;
            idx     <= 3'd5;
            code_sr <= '0;
          end
        end
        ENC: begin
          rem     <= rem_next;
          code_sr <= code_next;
          if (idx == 3'd0) begin
            // Whole word is only ever published here, never partially.
            codeout_r   <= code_next;
            enc_err_r   <= (rem_next != '0);
            out_valid_r <= 1'b1;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        HOLD: begin
          if (bus.out_ready) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fns_enc_4_2_seq.sv
module tb_fns_enc_4_2_seq;

  logic       clk;
  logic       rst_n;
  logic [5:0] en_flag;
  logic [3:0] fns03, fns04, fns05, fns06;
  logic [1:0] fsm_state;

  fns_enc_4_2_seq_if #(.DATA_W(4)) bus ();

  fns_enc_4_2_seq #(.DATA_W(4), .WW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .en_flag   (en_flag),
    .FNS03     (fns03),
    .FNS04     (fns04),
    .FNS05     (fns05),
    .FNS06     (fns06),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // scoreboard: {enc_err, codeout} expected per accepted word
  logic [6:0] exp_q[$];
  int         lat_q[$];
  int         last_acc = 0;
  int         last_hs  = 0;
  logic       prev_ov  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (lat_q.size() == 0) check("latency_unexpected", 32'd1, 32'd0);
        else check("latency", cyc - lat_q.pop_front(), 6);
      end
      if (bus.out_valid && bus.out_ready) begin
        last_hs = cyc + 1;
        if (exp_q.size() == 0) check("unexpected_output", {25'd0, bus.enc_err, bus.codeout}, 32'h7f);
        else check("codeword", {25'd0, bus.enc_err, bus.codeout}, {25'd0, exp_q.pop_front()});
      end
      prev_ov = bus.out_valid;
    end
  end

  // driver tasks (all driving happens 1 time unit after a rising edge)
  task automatic send(input logic [3:0] data, input logic [6:0] exp);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    bus.data_in  = data;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(cyc + 1);
    last_acc = cyc + 1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic set_default_cfg();
    en_flag = 6'b111111;
    fns03 = 4'd2; fns04 = 4'd3; fns05 = 4'd5; fns06 = 4'd8;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, hs1, n;
    rst_n = 1'b0;
    bus.data_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_default_cfg();
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_codeout",   bus.codeout,   0);
    check("rst_enc_err",   bus.enc_err,   0);
    check("rst_state",     fsm_state,     0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single word, latency 6
    send(4'd13, {1'b0, 6'b110000});
    wait_drain();

    // back-to-back with out_ready high
    send(4'd7, {1'b0, 6'b010100});
    acc1 = last_acc;
    send(4'd15, {1'b0, 6'b110100});
    hs1 = last_hs;
    check("throughput", last_acc - acc1, 8);
    check("in_ready_after_hs", last_acc, hs1 + 1);
    wait_drain();

    // wire 5 disabled
    en_flag = 6'b011111;
    send(4'd7,  {1'b0, 6'b010100});
    send(4'd13, {1'b1, 6'b011111});
    wait_drain();
    set_default_cfg();

    // output stall: everything holds, extra in_valid ignored
    bus.out_ready = 1'b0;
    send(4'd15, {1'b0, 6'b110100});
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("stall_wait_timeout", 32'd1, 32'd0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.data_in  = 4'd1;
      @(negedge clk);
      check("stall_codeout",   bus.codeout,   6'b110100);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready",  bus.in_ready,  0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready",  bus.in_ready,  1);
    wait_drain();

    // config changes after acceptance must not affect the word
    send(4'd13, {1'b0, 6'b110000});
    en_flag = 6'b000000;
    fns06   = 4'd0;
    wait_drain();
    set_default_cfg();

    // zero weight on an enabled wire: bit set, remainder unchanged
    fns03 = 4'd0;
    send(4'd3, {1'b0, 6'b001100});
    wait_drain();
    set_default_cfg();

    // nothing enabled: all-zero codeword, error flagged
    en_flag = 6'b000000;
    send(4'd15, {1'b1, 6'b000000});
    wait_drain();
    set_default_cfg();

    // reset during the third ENC cycle aborts the word
    send(4'd13, {1'b0, 6'b110000});
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_codeout",   bus.codeout,   0);
    check("abort_in_ready",  bus.in_ready,  1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'd0, {1'b0, 6'b000000});
    wait_drain();

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
